// File: rtl/decode_stage.sv
// Decode stage of the 27-bit RIDA pipeline: instruction decode, 16-entry register file
// with write-through, and the D/E pipeline register with wrong-path bubble insertion.
module decode_stage #(
  parameter int NREGS = 16,
  parameter int XLEN  = 27,
  localparam int AW   = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] InstrD,
  input  logic [XLEN-1:0] PCD,
  input  logic [XLEN-1:0] PCPlus4D,
  input  logic            PCSrcE,
  input  logic            RegWriteW,
  input  logic [AW-1:0]   RdW,
  input  logic [XLEN-1:0] ResultW,
  output logic [XLEN-1:0] RD1E,
  output logic [XLEN-1:0] RD2E,
  output logic [XLEN-1:0] ImmExtE,
  output logic [XLEN-1:0] PCE,
  output logic [XLEN-1:0] PCPlus4E,
  output logic [AW-1:0]   Rs1E,
  output logic [AW-1:0]   Rs2E,
  output logic [AW-1:0]   RdE,
  output logic            RegWriteE,
  output logic            MemWriteE,
  output logic            BranchE,
  output logic            JumpE,
  output logic            ALUSrcE,
  output logic            IllegalE,
  output logic [1:0]      ResultSrcE,
  output logic [2:0]      ALUControlE
);

  logic [XLEN-1:0] r_regs [NREGS];
  logic            r_kill_pending;

  logic [4:0]      w_op;
  logic [AW-1:0]   w_a1, w_a2, w_rd;
  logic [XLEN-1:0] w_rd1, w_rd2, w_imm;
  logic            w_reg_write, w_mem_write, w_branch, w_jump, w_alu_src, w_illegal;
  logic            w_a2_rd, w_bubble;
  logic [1:0]      w_result_src;
  logic [2:0]      w_alu_ctl;

  assign w_op = InstrD[26:22];
  assign w_rd = InstrD[21:18];
  assign w_a1 = InstrD[17:14];
  // STORE and BEQ carry their second source operand in the rd field
  assign w_a2 = w_a2_rd ? InstrD[21:18] : InstrD[13:10];

  always_comb begin
    w_reg_write  = 1'b0;
    w_mem_write  = 1'b0;
    w_branch     = 1'b0;
    w_jump       = 1'b0;
    w_alu_src    = 1'b0;
    w_illegal    = 1'b0;
    w_a2_rd      = 1'b0;
    w_result_src = 2'b00;
    w_alu_ctl    = 3'b000;
    w_imm        = {{(XLEN-14){InstrD[13]}}, InstrD[13:0]};
    casez (w_op)
      5'b00???: begin
        w_reg_write = 1'b1;
        w_alu_ctl   = w_op[2:0];
      end
      5'b01???: begin
        w_reg_write = 1'b1;
        w_alu_src   = 1'b1;
        w_alu_ctl   = w_op[2:0];
      end
      5'b10000: begin
        w_reg_write  = 1'b1;
        w_alu_src    = 1'b1;
        w_result_src = 2'b01;
      end
      5'b10001: begin
        w_mem_write = 1'b1;
        w_alu_src   = 1'b1;
        w_a2_rd     = 1'b1;
      end
      5'b11000: begin
        w_branch  = 1'b1;
        w_alu_ctl = 3'b001;
        w_a2_rd   = 1'b1;
      end
      5'b11010: begin
        w_jump       = 1'b1;
        w_reg_write  = 1'b1;
        w_result_src = 2'b10;
        w_imm        = {{(XLEN-18){InstrD[17]}}, InstrD[17:0]};
      end
      default: w_illegal = 1'b1;
    endcase
  end

  // Write-through lets an instruction in D see the value being written back this cycle
  assign w_rd1 = (w_a1 == '0) ? '0 :
                 (RegWriteW && RdW == w_a1) ? ResultW : r_regs[w_a1];
  assign w_rd2 = (w_a2 == '0) ? '0 :
                 (RegWriteW && RdW == w_a2) ? ResultW : r_regs[w_a2];

  assign w_bubble = PCSrcE | r_kill_pending;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
    end else if (RegWriteW && RdW != '0) begin
      r_regs[RdW] <= ResultW;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_kill_pending <= 1'b0;
      RD1E           <= '0;
      RD2E           <= '0;
      ImmExtE        <= '0;
      PCE            <= '0;
      PCPlus4E       <= '0;
      Rs1E           <= '0;
      Rs2E           <= '0;
      RdE            <= '0;
      RegWriteE      <= 1'b0;
      MemWriteE      <= 1'b0;
      BranchE        <= 1'b0;
      JumpE          <= 1'b0;
      ALUSrcE        <= 1'b0;
      IllegalE       <= 1'b0;
      ResultSrcE     <= 2'b00;
      ALUControlE    <= 3'b000;
    end else begin
      r_kill_pending <= PCSrcE;
      RD1E           <= w_rd1;
      RD2E           <= w_rd2;
      ImmExtE        <= w_imm;
      PCE            <= PCD;
      PCPlus4E       <= PCPlus4D;
      Rs1E           <= w_a1;
      Rs2E           <= w_a2;
      RdE            <= w_rd;
      // A bubble only suppresses side-effecting controls; data fields pass through
      RegWriteE      <= w_reg_write & ~w_bubble;
      MemWriteE      <= w_mem_write & ~w_bubble;
      BranchE        <= w_branch & ~w_bubble;
      JumpE          <= w_jump & ~w_bubble;
      IllegalE       <= w_illegal & ~w_bubble;
      ALUSrcE        <= w_alu_src;
      ResultSrcE     <= w_result_src;
      ALUControlE    <= w_alu_ctl;
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: reset, register file, immediates, decode and
// wrong-path kill behaviour against hand-computed values.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [26:0] InstrD, PCD, PCPlus4D, ResultW;
  logic        PCSrcE, RegWriteW;
  logic [3:0]  RdW;
  logic [26:0] RD1E, RD2E, ImmExtE, PCE, PCPlus4E;
  logic [3:0]  Rs1E, Rs2E, RdE;
  logic        RegWriteE, MemWriteE, BranchE, JumpE, ALUSrcE, IllegalE;
  logic [1:0]  ResultSrcE;
  logic [2:0]  ALUControlE;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  decode_stage dut (
    .clk(clk), .rst(rst), .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D),
    .PCSrcE(PCSrcE), .RegWriteW(RegWriteW), .RdW(RdW), .ResultW(ResultW),
    .RD1E(RD1E), .RD2E(RD2E), .ImmExtE(ImmExtE), .PCE(PCE), .PCPlus4E(PCPlus4E),
    .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE), .RegWriteE(RegWriteE), .MemWriteE(MemWriteE),
    .BranchE(BranchE), .JumpE(JumpE), .ALUSrcE(ALUSrcE), .IllegalE(IllegalE),
    .ResultSrcE(ResultSrcE), .ALUControlE(ALUControlE)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [10:0] ctl_now();
    return {RegWriteE, MemWriteE, BranchE, JumpE, ALUSrcE, IllegalE, ResultSrcE, ALUControlE};
  endfunction

  function automatic logic [10:0] c(input bit rw, mw, br, jp, as, il,
                                    input logic [1:0] rs, input logic [2:0] al);
    return {rw, mw, br, jp, as, il, rs, al};
  endfunction

  function automatic logic [26:0] rtype(input logic [4:0] op, input logic [3:0] rd, rs1, rs2);
    return {op, rd, rs1, rs2, 10'b0};
  endfunction

  function automatic logic [26:0] itype(input logic [4:0] op, input logic [3:0] rd, rs1,
                                        input logic [13:0] imm);
    return {op, rd, rs1, imm};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [26:0] add_i;

  initial begin
    rst       = 1'b1;
    InstrD    = 27'($urandom);
    PCD       = 27'($urandom);
    PCPlus4D  = 27'($urandom);
    ResultW   = 27'($urandom);
    PCSrcE    = 1'b0;
    RegWriteW = 1'b1;
    RdW       = 4'd5;
    #3 rst = 1'b0;
    repeat (3) begin
      InstrD = 27'($urandom);
      PCD    = 27'($urandom);
      PCSrcE = 1'($urandom);
      tick();
    end
    check("rst_rd1", {5'b0, RD1E}, 0);
    check("rst_rd2", {5'b0, RD2E}, 0);
    check("rst_imm", {5'b0, ImmExtE}, 0);
    check("rst_pc", {5'b0, PCE}, 0);
    check("rst_pc4", {5'b0, PCPlus4E}, 0);
    check("rst_idx", {20'b0, Rs1E, Rs2E, RdE}, 0);
    check("rst_ctl", {21'b0, ctl_now()}, 0);

    RegWriteW = 1'b0; RdW = '0; ResultW = '0; PCSrcE = 1'b0;
    InstrD = '0; PCD = '0; PCPlus4D = '0;
    rst = 1'b1;
    for (int i = 1; i < 16; i++) begin
      InstrD = rtype(5'b00000, 4'd0, 4'(i), 4'(i));
      tick();
      check($sformatf("rst_r%0d_a", i), {5'b0, RD1E}, 0);
      check($sformatf("rst_r%0d_b", i), {5'b0, RD2E}, 0);
    end

    RegWriteW = 1'b1; RdW = 4'd3; ResultW = 27'h155AAAA;
    InstrD = rtype(5'b00000, 4'd1, 4'd3, 4'd0);
    tick();
    check("wt_rd1", {5'b0, RD1E}, 32'h155AAAA);
    check("wt_rs1", {28'b0, Rs1E}, 3);
    RegWriteW = 1'b0;
    InstrD = rtype(5'b00000, 4'd1, 4'd0, 4'd3);
    tick();
    check("wr_landed", {5'b0, RD2E}, 32'h155AAAA);

    RegWriteW = 1'b1; RdW = 4'd0; ResultW = 27'h1234567;
    InstrD = rtype(5'b00000, 4'd0, 4'd0, 4'd0);
    tick();
    check("r0_wt", {5'b0, RD1E}, 0);
    RegWriteW = 1'b0;
    tick();
    check("r0_after", {5'b0, RD1E}, 0);

    InstrD = itype(5'b01011, 4'd2, 4'd0, 14'h3FFF);
    tick();
    check("itype_imm", {5'b0, ImmExtE}, 32'h7FFFFFF);
    check("itype_ctl", {21'b0, ctl_now()}, {21'b0, c(1,0,0,0,1,0,2'b00,3'b011)});

    InstrD = {5'b11010, 4'd1, 18'h00010}; PCD = 27'h100; PCPlus4D = 27'h101;
    tick();
    check("jal_imm", {5'b0, ImmExtE}, 32'h10);
    check("jal_ctl", {21'b0, ctl_now()}, {21'b0, c(1,0,0,1,0,0,2'b10,3'b000)});
    check("jal_pc", {5'b0, PCE}, 32'h100);
    check("jal_pc4", {5'b0, PCPlus4E}, 32'h101);

    RegWriteW = 1'b1; RdW = 4'd5; ResultW = 27'd7; InstrD = '0;
    tick();
    RdW = 4'd2; ResultW = 27'd9;
    tick();
    RegWriteW = 1'b0;
    InstrD = itype(5'b10001, 4'd5, 4'd2, 14'h0004);
    tick();
    check("st_rs2", {28'b0, Rs2E}, 5);
    check("st_rd2", {5'b0, RD2E}, 7);
    check("st_rd1", {5'b0, RD1E}, 9);
    check("st_ctl", {21'b0, ctl_now()}, {21'b0, c(0,1,0,0,1,0,2'b00,3'b000)});
    check("st_imm", {5'b0, ImmExtE}, 4);

    InstrD = itype(5'b10000, 4'd6, 4'd2, 14'h2000);
    tick();
    check("ld_ctl", {21'b0, ctl_now()}, {21'b0, c(1,0,0,0,1,0,2'b01,3'b000)});
    check("ld_imm", {5'b0, ImmExtE}, 32'h7FFE000);
    check("ld_rd", {28'b0, RdE}, 6);

    InstrD = itype(5'b11000, 4'd5, 4'd2, 14'h3FFE);
    tick();
    check("beq_ctl", {21'b0, ctl_now()}, {21'b0, c(0,0,1,0,0,0,2'b00,3'b001)});
    check("beq_rs2", {28'b0, Rs2E}, 5);
    check("beq_rd2", {5'b0, RD2E}, 7);
    check("beq_imm", {5'b0, ImmExtE}, 32'h7FFFFFE);

    add_i = rtype(5'b00000, 4'd1, 4'd2, 4'd5);
    InstrD = add_i;
    tick();
    check("kill_pre", {31'b0, RegWriteE}, 1);
    PCSrcE = 1'b1; RegWriteW = 1'b1; RdW = 4'd7; ResultW = 27'h42; PCD = 27'h200;
    tick();
    check("kill_b1", {31'b0, RegWriteE}, 0);
    check("kill_b1_pc", {5'b0, PCE}, 32'h200);
    PCSrcE = 1'b0; RegWriteW = 1'b0;
    tick();
    check("kill_b2", {31'b0, RegWriteE}, 0);
    tick();
    check("kill_pass", {31'b0, RegWriteE}, 1);
    InstrD = rtype(5'b00000, 4'd1, 4'd7, 4'd0);
    tick();
    check("kill_wb", {5'b0, RD1E}, 32'h42);

    InstrD = add_i; PCSrcE = 1'b1;
    tick();
    check("kill2_b1", {31'b0, RegWriteE}, 0);
    tick();
    check("kill2_b2", {31'b0, RegWriteE}, 0);
    PCSrcE = 1'b0;
    tick();
    check("kill2_b3", {31'b0, RegWriteE}, 0);
    tick();
    check("kill2_pass", {31'b0, RegWriteE}, 1);

    InstrD = {5'b11111, 22'h0};
    tick();
    check("ill_ctl", {21'b0, ctl_now()}, {21'b0, c(0,0,0,0,0,1,2'b00,3'b000)});
    PCSrcE = 1'b1;
    tick();
    check("ill_kill", {21'b0, ctl_now()}, 0);

    InstrD = add_i; PCD = 27'h300;
    tick();
    check("mid_pc", {5'b0, PCE}, 32'h300);
    PCSrcE = 1'b0;
    rst = 1'b0;
    #2;
    check("mid_rst_pc", {5'b0, PCE}, 0);
    check("mid_rst_rd1", {5'b0, RD1E}, 0);
    rst = 1'b1;
    tick();
    check("post_rst_rw", {31'b0, RegWriteE}, 1);
    check("post_rst_rd2", {5'b0, RD2E}, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
# decode_stage

Decode stage of the 27-bit RIDA pipeline, directly downstream of instruction fetch. Consumes the fetch pipeline register (InstrD, PCD, PCPlus4D), decodes the instruction and reads a 16 x 27-bit register file. Writeback also lands in that register file. Drives the Decode/Execute pipeline register and inserts bubbles for wrong-path instructions after a taken branch or jump.

## Interface
- NREGS, 16, register file depth (4-bit register fields)
- XLEN, 27, datapath and instruction width
- clk  in  1  clock, all state updates on posedge
- rst  in  1  reset, asynchronous, active-low
- InstrD, PCD, PCPlus4D  in  27 each  from fetch pipeline register
- PCSrcE  in  1  taken branch/jump resolved in Execute
- RegWriteW  in  1  writeback enable
- RdW  in  4  writeback register
- ResultW  in  27  writeback data
- RD1E, RD2E  out  27  register operands
- ImmExtE  out  27  sign-extended immediate
- PCE, PCPlus4E  out  27  PC values passed to Execute
- Rs1E, Rs2E, RdE  out  4  register indices for forwarding/writeback
- RegWriteE, MemWriteE, BranchE, JumpE, ALUSrcE, IllegalE  out  1 each  controls
- ResultSrcE  out  2  00 ALU, 01 memory, 10 PC+1
- ALUControlE  out  3  ALU operation

## Operation
- Fields: opcode [26:22], rd [21:18], rs1 [17:14], rs2 [13:10], imm14 [13:0], imm18 [17:0].
- A1 = rs1 always. A2 = rs2 for R-type, rd field for STORE and BEQ.
- opcode[26:25]=00 R-type: RegWrite=1, ALUSrc=0, ALUControl=opcode[24:22], ResultSrc=00.
- opcode[26:25]=01 I-type: as R-type but ALUSrc=1, Imm=sext(imm14).
- 10000 LOAD: RegWrite=1, ALUSrc=1, ALUControl=000 (add), ResultSrc=01, Imm=sext(imm14).
- 10001 STORE: MemWrite=1, ALUSrc=1, ALUControl=000, Imm=sext(imm14), RegWrite=0.
- 11000 BEQ: Branch=1, ALUControl=001 (sub), Imm=sext(imm14). Compares R[rs1] with R[rd field]; target PC+Imm.
- 11010 JAL: Jump=1, RegWrite=1, ResultSrc=10, Imm=sext(imm18).
- 00000 with all other bits zero is NOP and decodes as R-type writing R0, i.e. no effect.
- Any other opcode: all controls 0, IllegalE=1.
- RdE = rd field for every opcode (RegWriteE gates its use). Rs1E = A1, Rs2E = A2.
- Register file: R0 reads 0; writes to R0 ignored. Write occurs at posedge when RegWriteW.
- Write-through: if RegWriteW and RdW==An and An!=0, the read returns ResultW in the same cycle.
- Load-use hazards are not interlocked; software inserts one NOP after LOAD. Fetch has no stall input, so this stage never stalls.
- Wrong-path kill: when PCSrcE=1, the instruction in D (fetched sequentially) is killed. A kill_pending flag is set so the next instruction entering D is also killed.
- A killed instruction loads a bubble into D/E: RegWriteE, MemWriteE, BranchE, JumpE, IllegalE all 0. Data fields load normally.

## Timing
- Reset (async, rst=0): all D/E outputs 0, all 16 registers 0, kill_pending 0.
- Latency: D/E outputs reflect InstrD one posedge later. Register read is combinational within D.
- kill_pending <= PCSrcE each posedge. Bubble condition = PCSrcE | kill_pending.
- If PCSrcE is asserted two cycles in a row, the kill window extends; the bubble condition is evaluated every cycle.
- Writeback is unaffected by bubbles: regfile writes proceed during flush cycles.
- Simultaneous write and read of the same register: the write-through returns the new value, and it is latched into RD1E/RD2E at the same edge the regfile updates.
- Reset asserted mid-operation clears state immediately. The first posedge after release decodes the current InstrD normally with no pending kill.

## Test plan
- Reset: hold rst=0 with random inputs -> every output 0. Reading R1..R15 after release returns 0.
- Write/read: RegWriteW=1, RdW=3, ResultW=27'h155AAAA with InstrD R-type rs1=3 in the same cycle -> RD1E=27'h155AAAA next edge. RdW=0 write -> R0 still reads 0.
- Immediate: I-type imm14=14'h3FFF -> ImmExtE=27'h7FFFFFF. JAL imm18=18'h00010 -> ImmExtE=27'h10, JumpE=1, ResultSrcE=10.
- STORE rd=5 rs1=2: set R5=7 and R2=9 -> Rs2E=5, RD2E=7, RD1E=9, MemWriteE=1, RegWriteE=0.
- Kill: PCSrcE=1 for one cycle during a stream of ADDs -> exactly two consecutive bubbles in E (RegWriteE=0). The third instruction passes with RegWriteE=1. A concurrent RegWriteW write still lands.
- Illegal opcode 11111 -> IllegalE=1 and all other controls 0. Same opcode under PCSrcE=1 -> IllegalE=0.
